// File: rtl/vga_pkg.sv
// Shared definitions for the name-table write path: map geometry, RAM
// widths, command opcodes and the command bundle queued by the writer.
package vga_pkg;

    localparam int COLS        = 40;
    localparam int ROWS        = 30;
    localparam int NAME_ADDR_W = 11;
    localparam int TILE_W      = 8;
    localparam int ROW_W       = 5;
    localparam int COL_W       = 6;
    localparam int FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'd0,
        OP_FILL_ROW = 2'd1,
        OP_FILL_ALL = 2'd2,
        OP_NOP      = 2'd3
    } cmd_op_e;

    typedef struct packed {
        cmd_op_e             op;
        logic [ROW_W-1:0]    row;
        logic [COL_W-1:0]    col;
        logic [TILE_W-1:0]   tile;
    } name_cmd_t;

endpackage

// File: rtl/name_table_writer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO of name-table commands with full/empty flags.
// Ports: clk, rst_n, push_i/data_i (write), pop_i/data_o (read), full_o, empty_o.
module cmd_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  name_cmd_t data_i,
    input  logic      pop_i,
    output name_cmd_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    name_cmd_t     mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i && !full_o) begin
                mem_q[wptr_q[AW-1:0]] <= data_i;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/name_table_writer.sv
// name_table_writer: sole writer of the 40x30 name RAM. Queues tile commands
// (write / fill row / fill all) and issues writes only while blank_ok is high.
// Ports: cmd_* valid/ready command input, blank_ok write window,
// we/waddr/wdata registered RAM write port, busy and done status.
module name_table_writer #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_col,
    input  logic [4:0]  cmd_row,
    input  logic [7:0]  cmd_tile,
    input  logic        blank_ok,
    output logic        we,
    output logic [10:0] waddr,
    output logic [7:0]  wdata,
    output logic        busy,
    output logic        done
);

    import vga_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    name_cmd_t              cmd_in;
    name_cmd_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;

    state_e                 state_q;
    cmd_op_e                op_q;
    logic [ROW_W-1:0]       row_q;
    logic [COL_W-1:0]       col_q;
    logic [TILE_W-1:0]      tile_q;
    logic                   we_q;
    logic                   done_q;
    logic [NAME_ADDR_W-1:0] waddr_q;
    logic [TILE_W-1:0]      wdata_q;

    cmd_op_e                op_d;
    logic [ROW_W-1:0]       row_d;
    logic [COL_W-1:0]       col_d;
    logic [TILE_W-1:0]      tile_d;
    logic [ROW_W-1:0]       row_nx_d;
    logic [COL_W-1:0]       col_nx_d;
    logic                   last_d;
    logic                   drop_d;

    assign cmd_in = '{
        op:   cmd_op_e'(cmd_op),
        row:  cmd_row,
        col:  cmd_col,
        tile: cmd_tile
    };

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state_q == ST_LOAD);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (cmd_in),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Position to write this cycle: taken straight from the FIFO head in
    // LOAD so the first write needs no extra cycle, else from the counters.
    always_comb begin
        op_d   = op_q;
        row_d  = row_q;
        col_d  = col_q;
        tile_d = tile_q;
        drop_d = 1'b0;
        if (state_q == ST_LOAD) begin
            op_d   = head.op;
            tile_d = head.tile;
            unique case (head.op)
                OP_WRITE: begin
                    row_d  = head.row;
                    col_d  = head.col;
                    drop_d = (int'(head.row) >= ROWS) ||
                             (int'(head.col) >= COLS);
                end
                OP_FILL_ROW: begin
                    row_d  = head.row;
                    col_d  = '0;
                    drop_d = (int'(head.row) >= ROWS);
                end
                OP_FILL_ALL: begin
                    row_d  = '0;
                    col_d  = '0;
                end
                default: begin
                    row_d  = '0;
                    col_d  = '0;
                    drop_d = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        if (col_d == COL_LAST) begin
            col_nx_d = '0;
            row_nx_d = row_d + ROW_W'(1);
        end else begin
            col_nx_d = col_d + COL_W'(1);
            row_nx_d = row_d;
        end
        last_d = (op_d == OP_WRITE) ||
                 ((col_d == COL_LAST) &&
                  ((op_d == OP_FILL_ROW) || (row_d == ROW_LAST)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_WRITE;
            row_q   <= '0;
            col_q   <= '0;
            tile_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // A push this cycle makes the head valid next cycle.
                    if (!fifo_empty || push) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD, ST_RUN: begin
                    op_q   <= op_d;
                    tile_q <= tile_d;
                    if (drop_d) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (blank_ok) begin
                        we_q    <= 1'b1;
                        waddr_q <= {row_d, col_d};
                        wdata_q <= tile_d;
                        row_q   <= row_nx_d;
                        col_q   <= col_nx_d;
                        state_q <= last_d ? ST_DONE : ST_RUN;
                    end else begin
                        row_q   <= row_d;
                        col_q   <= col_d;
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign done  = done_q;
    assign busy  = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_name_table_writer.sv
// Randomized and directed bench for name_table_writer against a
// queue-based model of the expected name-RAM write stream.
module tb_name_table_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_col;
    logic [4:0]  cmd_row;
    logic [7:0]  cmd_tile;
    logic        blank_ok;
    logic        we;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_we    = 0;
    int          n_done  = 0;
    bit          rand_mode = 1'b0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    name_table_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_tile  (cmd_tile),
        .blank_ok  (blank_ok),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected writes of one accepted command, in issue order.
    task automatic model_cmd(input logic [1:0] op, input logic [4:0] row,
                             input logic [5:0] col, input logic [7:0] tile);
        int r;
        int c;
        r = int'(row);
        c = int'(col);
        case (op)
            2'd0: if (r < 30 && c < 40)
                exp_q.push_back({11'(r * 64 + c), tile});
            2'd1: if (r < 30)
                for (int k = 0; k < 40; k++)
                    exp_q.push_back({11'(r * 64 + k), tile});
            2'd2:
                for (int y = 0; y < 30; y++)
                    for (int x = 0; x < 40; x++)
                        exp_q.push_back({11'(y * 64 + x), tile});
            default: ;
        endcase
    endtask

    // One clock: advance to the next falling edge, then score outputs.
    task automatic tick();
        logic [18:0] e;
        @(posedge clk);
        @(negedge clk);
        if (rst_n) begin
            if (we) begin
                n_we++;
                chk("wr_expected", {31'b0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", waddr, e[18:8]);
                    chk("wr_data", wdata, e[7:0]);
                end
            end
            if (done) n_done++;
        end
        if (rand_mode) blank_ok = ($urandom % 4) != 0;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [4:0] row,
                            input logic [5:0] col, input logic [7:0] tile);
        int w;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_col   = col;
        cmd_tile  = tile;
        w = 0;
        while (!cmd_ready && w < 2000) begin
            tick();
            w++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", {31'b0, cmd_ready}, 1);
        end else begin
            model_cmd(op, row, col, tile);
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] row,
                           input logic [5:0] col, input logic [7:0] tile,
                           input int pause_at, input int pause_len,
                           output int lat, output int nwe, output int span);
        int          we0;
        int          first;
        int          last;
        int          pz;
        logic [10:0] hold;
        we0   = n_we;
        first = -1;
        last  = -1;
        pz    = 0;
        hold  = '0;
        push_cmd(op, row, col, tile);
        lat = 1;
        while (!done && lat < 3000) begin
            tick();
            lat++;
            if (we) begin
                if (first < 0) first = lat;
                last = lat;
            end
            if (pz > 0) begin
                chk("pause_we", {31'b0, we}, 0);
                chk("hold_addr", waddr, hold);
                pz--;
                if (pz == 0) blank_ok = 1'b1;
            end else if (pause_at > 0 && we && (n_we - we0) == pause_at) begin
                hold     = waddr;
                blank_ok = 1'b0;
                pz       = pause_len;
            end
        end
        chk("done_seen", {31'b0, done}, 1);
        nwe  = n_we - we0;
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    task automatic drain(input int bound);
        int w;
        w = 0;
        while (busy && w < bound) begin
            tick();
            w++;
        end
        chk("drain", {31'b0, busy}, 0);
    endtask

    initial begin
        int          lat;
        int          nwe;
        int          span;
        int          we0;
        int          d0;
        int          sel;
        logic [1:0]  op;
        logic [4:0]  rr [5];
        logic [5:0]  cc [5];
        logic [7:0]  tt [5];

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_row   = '0;
        cmd_col   = '0;
        cmd_tile  = '0;
        blank_ok  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_we", {31'b0, we}, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_ready", {31'b0, cmd_ready}, 1);

        // Single write, minimum latency.
        blank_ok = 1'b1;
        run_cmd(2'd0, 5'd3, 6'd5, 8'hA7, 0, 0, lat, nwe, span);
        chk("wr_lat", lat, 3);
        chk("wr_cnt", nwe, 1);
        chk("wr_hold_addr", waddr, 11'h0C5);
        chk("wr_hold_data", wdata, 8'hA7);
        tick();
        chk("wr_idle", {31'b0, busy}, 0);

        // Fill of the last row.
        run_cmd(2'd1, 5'd29, 6'd0, 8'h11, 0, 0, lat, nwe, span);
        chk("row_lat", lat, 42);
        chk("row_cnt", nwe, 40);
        chk("row_span", span, 40);
        chk("row_last", waddr, 11'h767);
        tick();

        // Full screen with a 10-cycle window closure mid-row.
        run_cmd(2'd2, 5'd0, 6'd0, 8'h00, 100, 10, lat, nwe, span);
        chk("all_cnt", nwe, 1200);
        chk("all_span", span, 1210);
        chk("all_lat", lat, 1212);
        tick();

        // Back-to-back writes with the window closed fill the FIFO.
        blank_ok = 1'b0;
        we0 = n_we;
        d0  = n_done;
        for (int i = 0; i < 5; i++) begin
            rr[i] = 5'($urandom_range(29, 0));
            cc[i] = 6'($urandom_range(39, 0));
            tt[i] = 8'($urandom);
            push_cmd(2'd0, rr[i], cc[i], tt[i]);
        end
        chk("full_ready", {31'b0, cmd_ready}, 0);
        chk("full_busy", {31'b0, busy}, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_row   = 5'd0;
        cmd_col   = 6'd0;
        cmd_tile  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold", {31'b0, cmd_ready}, 0);
        end
        cmd_valid = 1'b0;
        chk("full_nowe", n_we - we0, 0);
        blank_ok = 1'b1;
        drain(300);
        chk("five_we", n_we - we0, 5);
        chk("five_done", n_done - d0, 5);

        // Dropped commands still retire.
        run_cmd(2'd0, 5'd3, 6'd45, 8'h55, 0, 0, lat, nwe, span);
        chk("oor_col_we", nwe, 0);
        chk("oor_col_lat", lat, 2);
        tick();
        run_cmd(2'd0, 5'd31, 6'd2, 8'h55, 0, 0, lat, nwe, span);
        chk("oor_row_we", nwe, 0);
        tick();
        run_cmd(2'd1, 5'd30, 6'd0, 8'h66, 0, 0, lat, nwe, span);
        chk("oor_fill_we", nwe, 0);
        tick();
        run_cmd(2'd3, 5'd1, 6'd1, 8'h77, 0, 0, lat, nwe, span);
        chk("nop_we", nwe, 0);
        chk("nop_lat", lat, 2);
        tick();

        // Random command stream with a flickering write window.
        rand_mode = 1'b1;
        d0 = n_done;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom % 8);
            op  = (sel < 4 || sel == 7) ? 2'd0 : (sel < 6) ? 2'd1 : 2'd3;
            push_cmd(op, 5'($urandom_range(31, 0)),
                     6'($urandom_range(47, 0)), 8'($urandom));
        end
        drain(20000);
        rand_mode = 1'b0;
        blank_ok  = 1'b1;
        chk("rand_done", n_done - d0, 40);
        chk("rand_empty", exp_q.size(), 0);
        tick();

        // Reset during a full fill with two commands queued.
        push_cmd(2'd2, 5'd0, 6'd0, 8'h3C);
        push_cmd(2'd0, 5'd1, 6'd1, 8'h01);
        push_cmd(2'd0, 5'd2, 6'd2, 8'h02);
        repeat (50) tick();
        chk("pre_rst_busy", {31'b0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'b0, we}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_ready", {31'b0, cmd_ready}, 1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        we0 = n_we;
        d0  = n_done;
        repeat (30) tick();
        chk("post_rst_we", n_we - we0, 0);
        chk("post_rst_done", n_done - d0, 0);
        chk("post_rst_busy", {31'b0, busy}, 0);
        chk("post_rst_waddr", waddr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
